// File: rtl/pipe_pkg.sv
// Shared types and default widths for the inter-stage pipeline registers.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 128;
    localparam int unsigned PIPE_CTRL_W = 16;
    localparam int unsigned PIPE_CNT_W  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter for performance monitoring; holds at all-ones.
module pipe_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional skid entry, flush and
// control gating so that bubbles never carry write enables downstream.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned CTRL_W = PIPE_CTRL_W,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q, in_ready_d;
    logic              in_xfer, out_xfer;

    assign out_valid = (state_q != EMPTY);
    // Flush forces ready high so upstream never stalls on a beat being dropped.
    assign in_ready  = (SKID != 0) ? (in_ready_q | flush)
                                   : (out_ready | ~out_valid | flush);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d     = ONE;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_xfer && (SKID != 0)) begin
                        state_d     = TWO;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
        end
    end

    pipe_sat_cnt #(
        .W(CNT_W)
    ) u_bubble_cnt (
        .clk  (clk),
        .rst  (rst),
        .en_i (out_ready & ~out_valid),
        .cnt_o(bubble_cnt)
    );

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the CPU pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB), replacing the per-stage hand-written registers. It carries an opaque data payload and a control bundle between stages using a valid/ready handshake, with an optional skid entry. Flush squashes in-flight beats. Control bits are forced to zero whenever no valid beat is presented, so a bubble can never write the register file or memory. A saturating counter reports downstream bubble cycles for performance analysis.

## Interface
- DATA_W, 128, payload width (PC+4, instruction, operands, immediate)
- CTRL_W, 16, control bundle width (RegW, MemW, MemR, ALU ctrl, ...)
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
- CNT_W, 16, bubble counter width
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat this cycle
- in_data  input  DATA_W  upstream payload
- in_ctrl  input  CTRL_W  upstream control
- flush  input  1  squash all held beats and the incoming beat
- out_valid  output  1  beat presented downstream
- out_ready  input  1  downstream accepts
- out_data  output  DATA_W  payload of the presented beat
- out_ctrl  output  CTRL_W  control of the presented beat; all zero when out_valid=0
- bubble_cnt  output  CNT_W  saturating count of cycles with out_ready=1 and out_valid=0

## Operation
- Handshake: a beat transfers on a port when valid and ready are both 1 on a rising edge. Upstream holds in_valid/in_data/in_ctrl stable until accepted.
- States (SKID=1): EMPTY, ONE (main entry full), TWO (main and skid entries full).
  - EMPTY to ONE on an input transfer.
  - ONE to EMPTY on an output transfer with no input transfer.
  - ONE to TWO on an input transfer with no output transfer.
  - ONE stays in ONE when input and output transfer together; main entry is reloaded.
  - TWO to ONE on an output transfer; the skid entry moves to main.
- In TWO, in_ready=0. Otherwise in_ready=1.
- SKID=0: states EMPTY and ONE only. in_ready = out_ready | ~out_valid, combinational.
- out_valid=1 exactly in ONE or TWO. out_data and out_ctrl always come from the main entry.
- out_ctrl is gated to zero when out_valid=0.
- out_data keeps its last value in a bubble; it is not cleared.
- Flush has priority over every other event:
  - Next state is EMPTY.
  - Any incoming beat in the same cycle is dropped, and in_ready reads 1 that cycle so upstream does not stall.
  - Data registers are not cleared.
- bubble_cnt increments by 1 on every edge where out_ready=1 and out_valid=0. It saturates at 2^CNT_W-1 and does not wrap.
- Reset values:
  - state EMPTY, so out_valid=0.
  - out_ctrl=0, out_data=0, bubble_cnt=0.
  - in_ready=1.
  - Skid entry contents =0.
- Reset mid-operation discards all held beats immediately, without waiting for a clock edge.

## Timing
- Latency: in to out is 1 cycle. A beat accepted at edge n is presented at out_* after edge n.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- SKID=1: in_ready is a registered output with no combinational path from out_ready. It drops one cycle after a stall begins; the skid entry absorbs the beat already in flight.
- SKID=0: there is a combinational path from out_ready to in_ready. It is used only where the timing budget allows.
- Flush takes effect at the next edge: out_valid=0 and out_ctrl=0 from the cycle after flush is sampled.
- Ordering is strict FIFO. No beat is duplicated or lost except by flush or rst.

## Structure
- Shared package pipe_pkg holds:
  - the state typedef (EMPTY, ONE, TWO);
  - default width constants PIPE_DATA_W=128, PIPE_CTRL_W=16, PIPE_CNT_W=16.
- One sub-module, pipe_sat_cnt: a parametrised saturating up-counter (width, enable, async reset), reused by other performance counters.
- The entry storage and next-state logic stay in pipe_stage_reg.

## Test plan
- Reset then streaming: rst pulsed, then in_valid=1 with data 0x1..0x8, out_ready=1.
  - Required: in_ready=1 throughout.
  - Outputs 0x1..0x8 appear on consecutive cycles, each 1 cycle after acceptance.
  - bubble_cnt=1, counting only the first cycle.
- Back-pressure (SKID=1): out_ready=0 for 3 cycles mid-stream.
  - Required: in_ready drops the cycle after the stall begins; state reaches TWO.
  - After release, 0x3 then 0x4 are emitted in order with nothing lost.
- Flush with simultaneous input: state TWO, flush=1 with in_valid=1 and in_data=0x9.
  - Required: next cycle out_valid=0 and out_ctrl=0.
  - 0x9 never appears at the output, and in_ready=1.
- Bubble control gating: in_ctrl=0xFFFF with in_valid=0 for 4 cycles.
  - Required: out_ctrl=0x0000 and out_valid=0 on all 4 cycles.
  - bubble_cnt increases by 4 while out_ready=1.
- Counter saturation with CNT_W=4: 20 idle cycles with out_ready=1.
  - Required: bubble_cnt stops at 0xF and stays there.
- Asynchronous reset mid-stall: rst raised between edges while in state TWO.
  - Required: out_valid=0, out_ctrl=0 and in_ready=1 immediately, before the next clk edge.
